// File: rtl/regfile_pkg.sv
// Shared constants, address type and reset pattern for the multi-port register file.
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);
  localparam int RESET_VAL_W  = 32;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

  // Register i comes out of reset holding its own index.
  function automatic logic [RESET_VAL_W-1:0] reset_val(input int unsigned i);
    return RESET_VAL_W'(i);
  endfunction

endpackage

// File: rtl/regfile_fwd_mux.sv
// Per-read-port forwarding mux; forwards same-cycle write-back data when
// REGFILE_BYPASS_EN is defined, otherwise passes the array data straight through.
module regfile_fwd_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              wb0_en,
  input  logic [ADDR_W-1:0] wb0_dest,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic              wb1_en,
  input  logic [ADDR_W-1:0] wb1_dest,
  input  logic [DATA_W-1:0] wb1_data,
  output logic [DATA_W-1:0] data,
  output logic              hit
);

`ifdef REGFILE_BYPASS_EN
  logic wb0_hit;
  logic wb1_hit;

  assign wb0_hit = wb0_en && (wb0_dest == raddr);
  assign wb1_hit = wb1_en && (wb1_dest == raddr);

  // Load result is younger than the ALU result on a collision, so it wins.
  assign data = wb1_hit ? wb1_data : (wb0_hit ? wb0_data : arr_data);
  assign hit  = wb0_hit | wb1_hit;
`else
  logic unused_ok;

  assign unused_ok = ^{raddr, wb0_en, wb0_dest, wb0_data, wb1_en, wb1_dest, wb1_data};
  assign data      = arr_data;
  assign hit       = 1'b0;
`endif

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with two write-back ports and a per-register busy
// scoreboard. Same-cycle forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_dest,
  input  logic                     wb0_en,
  input  logic [ADDR_W-1:0]        wb0_dest,
  input  logic [DATA_W-1:0]        wb0_data,
  input  logic                     wb1_en,
  input  logic [ADDR_W-1:0]        wb1_dest,
  input  logic [DATA_W-1:0]        wb1_data,
  output logic [ADDR_W:0]          inflight_cnt
);

  logic [DATA_W-1:0]   regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;
  logic [ADDR_W:0]     cnt_reg;
  logic [ADDR_W:0]     cnt_next;

  // Issue sets, write-back clears; a set in the same cycle wins so the new producer stays pending.
  always_comb begin
    busy_next = '0;
    cnt_next  = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_next[r] = (issue_en && (issue_dest == ADDR_W'(r))) ||
                     (busy_reg[r] &&
                      !(wb0_en && (wb0_dest == ADDR_W'(r))) &&
                      !(wb1_en && (wb1_dest == ADDR_W'(r))));
      cnt_next = cnt_next + (ADDR_W+1)'(busy_next[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= DATA_W'(reset_val(i));
      end
      busy_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      if (wb0_en) regs_reg[wb0_dest] <= wb0_data;
      // Later assignment takes effect, so wb1 wins a same-destination collision.
      if (wb1_en) regs_reg[wb1_dest] <= wb1_data;
      busy_reg <= busy_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign inflight_cnt = cnt_reg;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] data;
    logic              hit;

    assign raddr = rd_addr[gi*ADDR_W +: ADDR_W];

    regfile_fwd_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_fwd (
      .raddr    (raddr),
      .arr_data (regs_reg[raddr]),
      .wb0_en   (wb0_en),
      .wb0_dest (wb0_dest),
      .wb0_data (wb0_data),
      .wb1_en   (wb1_en),
      .wb1_dest (wb1_dest),
      .wb1_data (wb1_data),
      .data     (data),
      .hit      (hit)
    );

    assign rd_data[gi*DATA_W +: DATA_W] = data;
    // A forwarded operand is already available, so it never stalls.
    assign rd_busy[gi] = busy_reg[raddr] & ~hit;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench for regfile_mp_sb: directed scenarios plus a random phase,
// checked against a reference model; follows REGFILE_BYPASS_EN like the design.
module tb_regfile_mp_sb;

  localparam int DW  = 32;
  localparam int NR  = 16;
  localparam int AW  = 4;
  localparam int NRD = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              issue_en;
  logic [AW-1:0]     issue_dest;
  logic              wb0_en;
  logic [AW-1:0]     wb0_dest;
  logic [DW-1:0]     wb0_data;
  logic              wb1_en;
  logic [AW-1:0]     wb1_dest;
  logic [DW-1:0]     wb1_data;
  logic [AW:0]       inflight_cnt;

  regfile_mp_sb #(
    .DATA_W   (DW),
    .NUM_REGS (NR),
    .NUM_RD   (NRD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_busy      (rd_busy),
    .issue_en     (issue_en),
    .issue_dest   (issue_dest),
    .wb0_en       (wb0_en),
    .wb0_dest     (wb0_dest),
    .wb0_data     (wb0_data),
    .wb1_en       (wb1_en),
    .wb1_dest     (wb1_dest),
    .wb1_data     (wb1_data),
    .inflight_cnt (inflight_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;   // 0 = rd_data, 1 = rd_busy, 2 = inflight_cnt
    int          port;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [DW-1:0] m_regs [NR];
  logic [NR-1:0] m_busy;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int kind, input int port, input logic [31:0] exp);
    sb_t e;
    e.tag = tag; e.kind = kind; e.port = port; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic idle();
    issue_en = 1'b0; wb0_en = 1'b0; wb1_en = 1'b0;
  endtask

  // Expected outputs for the current inputs and the model's architectural state.
  task automatic push_model();
    for (int p = 0; p < NRD; p++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          b;
      a = rd_addr[p*AW +: AW];
      d = m_regs[a];
      b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (wb1_en && wb1_dest == a) begin
        d = wb1_data; b = 1'b0;
      end else if (wb0_en && wb0_dest == a) begin
        d = wb0_data; b = 1'b0;
      end
`endif
      push($sformatf("model_data_p%0d_r%0d", p, a), 0, p, d);
      push($sformatf("model_busy_p%0d_r%0d", p, a), 1, p, {31'd0, b});
    end
    push("model_cnt", 2, 0, $countones(m_busy));
  endtask

  task automatic update_model();
    if (rst) begin
      for (int i = 0; i < NR; i++) m_regs[i] = DW'(i);
      m_busy = '0;
    end else begin
      if (wb0_en) m_regs[wb0_dest] = wb0_data;
      if (wb1_en) m_regs[wb1_dest] = wb1_data;
      if (wb0_en) m_busy[wb0_dest] = 1'b0;
      if (wb1_en) m_busy[wb1_dest] = 1'b0;
      if (issue_en) m_busy[issue_dest] = 1'b1;
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    push_model();
    @(negedge clk);
    while (sb.size() > 0) begin
      sb_t e;
      logic [63:0] obs;
      e = sb.pop_front();
      case (e.kind)
        0:       obs = 64'(rd_data[e.port*DW +: DW]);
        1:       obs = 64'(rd_busy[e.port]);
        default: obs = 64'(inflight_cnt);
      endcase
      check_val(e.tag, obs, 64'(e.exp));
    end
    @(posedge clk);
    update_model();
    #1;
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; issue_dest = '0;
    wb0_dest = '0; wb0_data = '0; wb1_dest = '0; wb1_data = '0;
    idle();
    m_busy = '0;
    @(posedge clk);
    update_model();
    #1;
    rst = 1'b0;

    // Reset then read
    set_rd(0, 4'd3); set_rd(1, 4'd15);
    push("rst_data_p0", 0, 0, 32'd3);
    push("rst_data_p1", 0, 1, 32'd15);
    push("rst_busy_p0", 1, 0, 32'd0);
    push("rst_busy_p1", 1, 1, 32'd0);
    push("rst_cnt", 2, 0, 32'd0);
    cycle();

    // Issue r5, then write it back through wb0
    issue_en = 1'b1; issue_dest = 4'd5;
    cycle();
    idle(); set_rd(0, 4'd5);
    push("issue_busy_r5", 1, 0, 32'd1);
    push("issue_cnt", 2, 0, 32'd1);
    cycle();
    wb0_en = 1'b1; wb0_dest = 4'd5; wb0_data = 32'hDEAD_BEEF;
    cycle();
    idle();
    push("wb_data_r5", 0, 0, 32'hDEAD_BEEF);
    push("wb_busy_r5", 1, 0, 32'd0);
    push("wb_cnt", 2, 0, 32'd0);
    cycle();

    // Dual-write collision on r7
    wb0_en = 1'b1; wb0_dest = 4'd7; wb0_data = 32'h1111;
    wb1_en = 1'b1; wb1_dest = 4'd7; wb1_data = 32'h2222;
    cycle();
    idle(); set_rd(0, 4'd7);
    push("collide_r7", 0, 0, 32'h2222);
    cycle();

    // Set beats clear on r4
    issue_en = 1'b1; issue_dest = 4'd4;
    cycle();
    wb1_en = 1'b1; wb1_dest = 4'd4; wb1_data = 32'h55;
    cycle();
    idle(); set_rd(0, 4'd4);
    push("setwin_data_r4", 0, 0, 32'h55);
    push("setwin_busy_r4", 1, 0, 32'd1);
    push("setwin_cnt", 2, 0, 32'd1);
    cycle();

    // Bypass behaviour on r2
    issue_en = 1'b1; issue_dest = 4'd2;
    cycle();
    idle(); set_rd(1, 4'd2);
    wb0_en = 1'b1; wb0_dest = 4'd2; wb0_data = 32'hABCD;
`ifdef REGFILE_BYPASS_EN
    push("byp_same_data", 0, 1, 32'hABCD);
    push("byp_same_busy", 1, 1, 32'd0);
`else
    push("nobyp_same_data", 0, 1, 32'd2);
    push("nobyp_same_busy", 1, 1, 32'd1);
`endif
    cycle();
    idle();
    push("byp_next_data", 0, 1, 32'hABCD);
    push("byp_next_busy", 1, 1, 32'd0);
    cycle();

    // Reset in the middle of activity
    issue_en = 1'b1;
    issue_dest = 4'd1; cycle();
    issue_dest = 4'd3; cycle();
    issue_dest = 4'd9; cycle();
    rst = 1'b1; issue_dest = 4'd6;
    wb0_en = 1'b1; wb0_dest = 4'd1; wb0_data = 32'h77;
    wb1_en = 1'b1; wb1_dest = 4'd1; wb1_data = 32'h88;
    cycle();
    rst = 1'b0; idle(); set_rd(0, 4'd1);
    push("midrst_data_r1", 0, 0, 32'd1);
    push("midrst_busy_r1", 1, 0, 32'd0);
    push("midrst_cnt", 2, 0, 32'd0);
    cycle();

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      rst        = ($urandom_range(0, 59) == 0);
      rd_addr    = NRD*AW'($urandom);
      issue_en   = $urandom_range(0, 1) == 1;
      issue_dest = AW'($urandom);
      wb0_en     = $urandom_range(0, 2) != 0;
      wb0_dest   = AW'($urandom);
      wb0_data   = $urandom;
      wb1_en     = $urandom_range(0, 2) == 0;
      wb1_dest   = AW'($urandom);
      wb1_data   = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
